light_conflict_monitor: RTL and testbench

//  Safety stage directly downstream of the traffic light controller. Samples the four lamp

---
 rtl/light_conflict_monitor_if.sv | 41 ++++
 rtl/light_conflict_monitor.sv | 172 +++++++++++++++++
 tb/tb_light_conflict_monitor.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/light_conflict_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : light_conflict_monitor_if
// Purpose  : Bundles the lamp buses between the traffic light controller, the
//            conflict monitor and the lamp drivers.
//            light_*     : controller lamp patterns {red,yellow,green}
//            fault_clr   : one-cycle clear request
//            out_*       : lamp driver patterns (same encoding)
//            fault       : monitor is in its fault state
//            fault_code  : first fault cause (0 none .. 4 short yellow)
//            fault_count : saturating count of fault entries
//            master drives the controller side, slave is the monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface light_conflict_monitor_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       light_M1;
    logic [2:0]       light_S;
    logic [2:0]       light_MT;
    logic [2:0]       light_M2;
    logic             fault_clr;
    logic [2:0]       out_M1;
    logic [2:0]       out_S;
    logic [2:0]       out_MT;
    logic [2:0]       out_M2;
    logic             fault;
    logic [2:0]       fault_code;
    logic [CNT_W-1:0] fault_count;

    modport master (
        output light_M1, light_S, light_MT, light_M2, fault_clr,
        input  out_M1, out_S, out_MT, out_M2, fault, fault_code, fault_count
    );

    modport slave (
        input  light_M1, light_S, light_MT, light_M2, fault_clr,
        output out_M1, out_S, out_MT, out_M2, fault, fault_code, fault_count
    );
endinterface
`default_nettype wire

// File: rtl/light_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module   : light_conflict_monitor
// Purpose  : Safety stage behind the traffic light controller. Every clock it
//            checks lamp encoding, cross-approach conflicts, lamp sequencing
//            and minimum yellow time; legal patterns reach the lamp drivers one
//            cycle later, a violation latches a fault and flashes red on all
//            approaches until cleared with all-red inputs.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - slave side of light_conflict_monitor_if (lamp in/out,
//                   fault_clr, fault, fault_code, fault_count)
// Revision : 1.0 - initial release
// ============================================================================
module light_conflict_monitor #(
    parameter int MIN_YELLOW     = 3,
    parameter int STARTUP_CYCLES = 4,
    parameter int FLASH_HALF     = 5,
    parameter int CNT_W          = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    light_conflict_monitor_if.slave bus
);
    localparam logic [2:0]       c_red        = 3'b100;
    localparam logic [2:0]       c_yel        = 3'b010;
    localparam logic [2:0]       c_grn        = 3'b001;
    localparam logic [CNT_W-1:0] c_min_yel    = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] c_start_last = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_flash_last = CNT_W'(FLASH_HALF - 1);
    localparam logic [CNT_W-1:0] c_cnt_max    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [3:0][2:0]        r_out;
    logic [3:0][2:0]        r_prev;
    logic [3:0][CNT_W-1:0]  r_ycnt;
    logic [CNT_W-1:0]       r_start_cnt;
    logic [CNT_W-1:0]       r_flash_cnt;
    logic                   r_phase;
    logic                   r_fault;
    logic [2:0]             r_code;
    logic [CNT_W-1:0]       r_count;

    // Lamp index: 0 = M1, 1 = S, 2 = MT, 3 = M2
    logic [3:0][2:0]        w_cur;
    logic [3:0]             w_non_red;
    logic                   w_enc;
    logic                   w_conf;
    logic                   w_seq;
    logic                   w_short;
    logic [2:0]             w_code;
    logic                   w_all_red;

    assign w_cur = {bus.light_M2, bus.light_MT, bus.light_S, bus.light_M1};

    always_comb begin
        w_enc     = 1'b0;
        w_seq     = 1'b0;
        w_short   = 1'b0;
        w_non_red = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_non_red[i] = (w_cur[i] != c_red);
            if (w_cur[i] != c_red && w_cur[i] != c_yel && w_cur[i] != c_grn)
                w_enc = 1'b1;
            if ((r_prev[i] == c_grn && w_cur[i] == c_red) ||
                (r_prev[i] == c_yel && w_cur[i] == c_grn) ||
                (r_prev[i] == c_red && w_cur[i] == c_yel))
                w_seq = 1'b1;
            // r_ycnt already includes the last yellow cycle
            if (r_prev[i] == c_yel && w_cur[i] == c_red && r_ycnt[i] < c_min_yel)
                w_short = 1'b1;
        end
        // Side road conflicts with every main lamp; main turn conflicts with M2
        w_conf = (w_non_red[1] && (w_non_red[0] || w_non_red[2] || w_non_red[3])) ||
                 (w_non_red[2] && w_non_red[3]);
        // Lowest code wins when several faults coincide
        if (w_enc)        w_code = 3'd1;
        else if (w_conf)  w_code = 3'd2;
        else if (w_seq)   w_code = 3'd3;
        else if (w_short) w_code = 3'd4;
        else              w_code = 3'd0;
        w_all_red = (w_cur == {4{c_red}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_STARTUP;
            r_out       <= {4{c_red}};
            r_prev      <= {4{c_red}};
            r_ycnt      <= '0;
            r_start_cnt <= '0;
            r_flash_cnt <= '0;
            r_phase     <= 1'b1;
            r_fault     <= 1'b0;
            r_code      <= 3'd0;
            r_count     <= '0;
        end else begin
            r_prev <= w_cur;
            for (int i = 0; i < 4; i++) begin
                if (w_cur[i] != c_yel)
                    r_ycnt[i] <= '0;
                else if (r_prev[i] != c_yel)
                    r_ycnt[i] <= CNT_W'(1);
                else if (r_ycnt[i] != c_cnt_max)
                    r_ycnt[i] <= r_ycnt[i] + 1'b1;
            end

            case (r_state)
                ST_STARTUP: begin
                    r_out <= {4{c_red}};
                    if (r_start_cnt == c_start_last) begin
                        r_start_cnt <= '0;
                        r_state     <= ST_MONITOR;
                    end else begin
                        r_start_cnt <= r_start_cnt + 1'b1;
                    end
                end
                ST_MONITOR: begin
                    if (w_code != 3'd0) begin
                        r_state     <= ST_FAULT;
                        r_fault     <= 1'b1;
                        r_code      <= w_code;
                        r_out       <= {4{c_red}};
                        r_flash_cnt <= '0;
                        r_phase     <= 1'b1;
                        if (r_count != c_cnt_max)
                            r_count <= r_count + 1'b1;
                    end else begin
                        r_out <= w_cur;
                    end
                end
                ST_FAULT: begin
                    if (bus.fault_clr && w_all_red) begin
                        r_state     <= ST_STARTUP;
                        r_fault     <= 1'b0;
                        r_code      <= 3'd0;
                        r_flash_cnt <= '0;
                        r_phase     <= 1'b1;
                        r_start_cnt <= '0;
                        r_out       <= {4{c_red}};
                    end else if (r_flash_cnt == c_flash_last) begin
                        r_flash_cnt <= '0;
                        r_phase     <= ~r_phase;
                        r_out       <= {4{~r_phase, 2'b00}};
                    end else begin
                        r_flash_cnt <= r_flash_cnt + 1'b1;
                        r_out       <= {4{r_phase, 2'b00}};
                    end
                end
                default: begin
                    r_state <= ST_STARTUP;
                    r_out   <= {4{c_red}};
                end
            endcase
        end
    end

    assign bus.out_M1      = r_out[0];
    assign bus.out_S       = r_out[1];
    assign bus.out_MT      = r_out[2];
    assign bus.out_M2      = r_out[3];
    assign bus.fault       = r_fault;
    assign bus.fault_code  = r_code;
    assign bus.fault_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_light_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_light_conflict_monitor
// Purpose  : Directed self-checking bench for light_conflict_monitor. A second
//            instance with MIN_YELLOW=2 shares the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_light_conflict_monitor;
    localparam logic [2:0]  c_r      = 3'b100;
    localparam logic [2:0]  c_y      = 3'b010;
    localparam logic [2:0]  c_g      = 3'b001;
    localparam logic [11:0] c_allred = 12'b100_100_100_100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    light_conflict_monitor_if #(.CNT_W(8)) bus ();
    light_conflict_monitor_if #(.CNT_W(8)) bus2 ();

    assign bus2.light_M1  = bus.light_M1;
    assign bus2.light_S   = bus.light_S;
    assign bus2.light_MT  = bus.light_MT;
    assign bus2.light_M2  = bus.light_M2;
    assign bus2.fault_clr = bus.fault_clr;

    light_conflict_monitor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    light_conflict_monitor #(.MIN_YELLOW(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic [2:0] m1, input logic [2:0] s,
                          input logic [2:0] mt, input logic [2:0] m2);
        bus.light_M1 = m1;
        bus.light_S  = s;
        bus.light_MT = mt;
        bus.light_M2 = m2;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.fault_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;
    endtask

    function automatic logic [11:0] outs();
        return {bus.out_M1, bus.out_S, bus.out_MT, bus.out_M2};
    endfunction

    function automatic logic [11:0] outs2();
        return {bus2.out_M1, bus2.out_S, bus2.out_MT, bus2.out_M2};
    endfunction

    initial begin
        bus.fault_clr = 1'b0;
        set_in(c_r, c_r, c_r, c_r);

        // 1: reset values, startup hold, legal cycle with 1-cycle latency
        set_in(c_g, c_r, c_r, c_g);
        do_reset();
        chk("reset_outs", outs(), c_allred);
        chk("reset_fault", bus.fault, 1'b0);
        chk("reset_code", bus.fault_code, 3'd0);
        chk("reset_count", bus.fault_count, 8'd0);
        step(4);
        chk("startup_red", outs(), c_allred);
        step();
        chk("track_green", outs(), {c_g, c_r, c_r, c_g});
        set_in(c_y, c_r, c_r, c_y);
        step();
        chk("track_yellow", outs(), {c_y, c_r, c_r, c_y});
        step(2);
        set_in(c_r, c_r, c_r, c_r);
        step();
        chk("track_red", outs(), c_allred);
        set_in(c_r, c_g, c_r, c_r);
        step();
        chk("track_side_green", outs(), {c_r, c_g, c_r, c_r});
        chk("legal_no_fault", bus.fault, 1'b0);

        // 2: conflict S/M1, then flashing red
        set_in(c_r, c_r, c_r, c_r);
        do_reset();
        step(4);
        set_in(c_g, c_r, c_r, c_r);
        step();
        chk("m1_green", outs(), {c_g, c_r, c_r, c_r});
        set_in(c_g, c_g, c_r, c_r);
        step();
        chk("conf_fault", bus.fault, 1'b1);
        chk("conf_code", bus.fault_code, 3'd2);
        chk("conf_count", bus.fault_count, 8'd1);
        chk("conf_outs", outs(), c_allred);
        step(4);
        chk("flash_on", outs(), c_allred);
        step();
        chk("flash_off", outs(), 12'd0);
        step(5);
        chk("flash_on2", outs(), c_allred);

        // 3: short yellow on M2 (2 cycles)
        set_in(c_r, c_r, c_r, c_r);
        do_reset();
        step(4);
        set_in(c_r, c_r, c_r, c_g);
        step();
        set_in(c_r, c_r, c_r, c_y);
        step(2);
        set_in(c_r, c_r, c_r, c_r);
        step();
        chk("short_y_fault", bus.fault, 1'b1);
        chk("short_y_code", bus.fault_code, 3'd4);
        chk("short_y_min2_fault", bus2.fault, 1'b0);
        chk("short_y_min2_outs", outs2(), c_allred);

        // 4a: MT green straight to red
        set_in(c_r, c_r, c_r, c_r);
        do_reset();
        step(4);
        set_in(c_r, c_r, c_g, c_r);
        step();
        set_in(c_r, c_r, c_r, c_r);
        step();
        chk("seq_code", bus.fault_code, 3'd3);

        // 4b: bad encoding
        do_reset();
        step(4);
        set_in(3'b011, c_r, c_r, c_r);
        step();
        chk("enc_code", bus.fault_code, 3'd1);
        chk("enc_outs", outs(), c_allred);

        // 4c: sequence (M1 G->R) and conflict (S with MT) together
        set_in(c_r, c_r, c_r, c_r);
        do_reset();
        step(4);
        set_in(c_g, c_r, c_r, c_r);
        step();
        set_in(c_r, c_g, c_g, c_r);
        step();
        chk("prio_fault", bus.fault, 1'b1);
        chk("prio_code", bus.fault_code, 3'd2);

        // 5: clear ignored with S green, honoured with all red
        set_in(c_r, c_g, c_r, c_r);
        pulse_clr();
        chk("clr_ignored_fault", bus.fault, 1'b1);
        chk("clr_ignored_code", bus.fault_code, 3'd2);
        set_in(c_r, c_r, c_r, c_r);
        pulse_clr();
        chk("clr_fault", bus.fault, 1'b0);
        chk("clr_code", bus.fault_code, 3'd0);
        chk("clr_count", bus.fault_count, 8'd1);
        chk("clr_outs", outs(), c_allred);
        step(4);
        chk("clr_startup_red", outs(), c_allred);
        set_in(c_g, c_r, c_r, c_r);
        step();
        chk("clr_monitor", outs(), {c_g, c_r, c_r, c_r});
        chk("clr_count_kept", bus.fault_count, 8'd1);

        // 6: async reset mid-FAULT (outs dark) and mid-STARTUP
        set_in(c_r, c_r, c_r, c_r);
        do_reset();
        step(4);
        set_in(3'b011, c_r, c_r, c_r);
        step();
        step(5);
        chk("pre_rst_dark", outs(), 12'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_outs", outs(), c_allred);
        chk("async_rst_fault", bus.fault, 1'b0);
        chk("async_rst_count", bus.fault_count, 8'd0);
        set_in(c_g, c_r, c_r, c_r);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        #1;
        chk("startup_rst_fault", bus.fault, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(4);
        chk("startup_rst_restart", outs(), c_allred);
        step();
        chk("startup_rst_monitor", outs(), {c_g, c_r, c_r, c_r});

        // 6b: fault count saturation
        set_in(c_r, c_r, c_r, c_r);
        do_reset();
        step(4);
        for (int k = 1; k <= 256; k++) begin
            set_in(3'b011, c_r, c_r, c_r);
            step();
            set_in(c_r, c_r, c_r, c_r);
            pulse_clr();
            step(4);
            if (k == 255)
                chk("count_255", bus.fault_count, 8'd255);
        end
        chk("count_sat", bus.fault_count, 8'd255);
        chk("sat_fault_clear", bus.fault, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
